// File: rtl/pipe_traffic_gen_pkg.sv
// Shared types and helpers for the pipe traffic generator.
// seq_value is the single definition of the expected sequence, used by the source and the sink.
package pipe_traffic_pkg;

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   // Callers truncate the result to their own data width, so width is limited to MAX_W.
   localparam int MAX_W = 64;
   localparam logic [MAX_W-1:0] SAT_ALL_ONES = '1;

   function automatic logic [MAX_W-1:0] seq_value(input logic [MAX_W-1:0] base,
                                                  input logic [MAX_W-1:0] idx);
      return base + idx;
   endfunction

endpackage

// File: rtl/pipe_traffic_gen_if.sv
// PipeIn (enqueue side) and PipeOut (dequeue side) of a pipe buffer.
// The traffic generator sits on the client modport of both.
interface PipeIn #(parameter int width = 32);
   logic             enq__ENA;
   logic [width-1:0] enq_v;
   logic             enq__RDY;

   modport client (output enq__ENA, enq_v, input enq__RDY);
   modport server (input enq__ENA, enq_v, output enq__RDY);
endinterface

interface PipeOut #(parameter int width = 32);
   logic             deq__ENA;
   logic             deq__RDY;
   logic [width-1:0] first;
   logic             first__RDY;

   modport client (output deq__ENA, input deq__RDY, first, first__RDY);
   modport server (input deq__ENA, output deq__RDY, first, first__RDY);
endinterface

// File: rtl/pipe_traffic_gen_seq_checker.sv
// Sink half of the traffic generator: drains the pipe, counts received items
// and compares each against the expected sequence with a saturating error count.
module pipe_seq_checker
   import pipe_traffic_pkg::*;
#(
   parameter int width = 32,
   parameter int cntw  = 16
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             clr,
   input  logic             run,
   input  logic [cntw-1:0]  count,
   input  logic [width-1:0] base,
   input  logic             deq_rdy,
   input  logic             first_rdy,
   input  logic [width-1:0] first,
   output logic             deq_ena,
   output logic             last,
   output logic [cntw-1:0]  errors
);

   localparam logic [cntw-1:0] ERR_MAX = cntw'(SAT_ALL_ONES);

   logic [cntw-1:0]  recv;
   logic [width-1:0] expect_v;

   // deq__ENA already includes both ready terms, so asserting it means the deq fires.
   always_comb begin
      expect_v = width'(seq_value(MAX_W'(base), MAX_W'(recv)));
      deq_ena  = run && (recv != count) && deq_rdy && first_rdy;
      last     = deq_ena && ((recv + cntw'(1)) == count);
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         recv   <= '0;
         errors <= '0;
      end else if (clr) begin
         recv   <= '0;
         errors <= '0;
      end else if (deq_ena) begin
         recv <= recv + cntw'(1);
         if ((first != expect_v) && (errors != ERR_MAX))
            errors <= errors + cntw'(1);
      end
   end

endmodule

// File: rtl/pipe_traffic_gen.sv
// Self-checking traffic harness: pushes base, base+1, ... into a pipe and checks
// what comes out, reporting done, error count and a no-progress timeout.
module pipe_traffic_gen
   import pipe_traffic_pkg::*;
#(
   parameter int width   = 32,
   parameter int cntw    = 16,
   parameter int timeout = 1023
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             start__ENA,
   output logic             start__RDY,
   input  logic [cntw-1:0]  start_count,
   input  logic [width-1:0] start_base,
   PipeIn.client            enq,
   PipeOut.client           deq,
   output logic             done,
   output logic [cntw-1:0]  errors,
   output logic             timed_out
);

   localparam int SW = (timeout < 1) ? 1 : $clog2(timeout + 1);

   state_t           state, state_nx;
   logic [cntw-1:0]  count, sent;
   logic [width-1:0] base;
   logic [SW-1:0]    stall;
   logic             start_acc, enq_fire, deq_ena, last, done_nx, abort;

   assign start_acc = start__ENA && (state == IDLE);
   assign enq_fire  = enq.enq__ENA && enq.enq__RDY;

   always_comb begin
      start__RDY = (state == IDLE);
      enq.enq__ENA = (state == RUN) && (sent != count);
      enq.enq_v    = width'(seq_value(MAX_W'(base), MAX_W'(sent)));
      deq.deq__ENA = deq_ena;
   end

   pipe_seq_checker #(.width(width), .cntw(cntw)) u_checker (
      .CLK       (CLK),
      .nRST      (nRST),
      .clr       (start_acc),
      .run       (state == RUN),
      .count     (count),
      .base      (base),
      .deq_rdy   (deq.deq__RDY),
      .first_rdy (deq.first__RDY),
      .first     (deq.first),
      .deq_ena   (deq_ena),
      .last      (last),
      .errors    (errors)
   );

   // Completion wins over timeout when both land in the same cycle.
   always_comb begin
      state_nx = state;
      done_nx  = 1'b0;
      abort    = 1'b0;
      case (state)
         IDLE: begin
            if (start_acc) begin
               if (start_count == '0) done_nx  = 1'b1;
               else                   state_nx = RUN;
            end
         end
         RUN: begin
            if (last) begin
               state_nx = IDLE;
               done_nx  = 1'b1;
            end else if (stall == SW'(timeout)) begin
               state_nx = IDLE;
               done_nx  = 1'b1;
               abort    = 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state     <= IDLE;
         done      <= 1'b0;
         count     <= '0;
         base      <= '0;
         sent      <= '0;
         stall     <= '0;
         timed_out <= 1'b0;
      end else begin
         state <= state_nx;
         done  <= done_nx;
         if (start_acc) begin
            count     <= start_count;
            base      <= start_base;
            sent      <= '0;
            stall     <= '0;
            timed_out <= 1'b0;
         end else if (state == RUN) begin
            if (enq_fire) sent <= sent + cntw'(1);
            stall <= (enq_fire || deq_ena) ? '0 : stall + SW'(1);
            if (abort) timed_out <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pipe_traffic_gen.sv
// Directed bench: pipe_traffic_gen driving a behavioural single-entry pipe
// that can also corrupt one item or refuse all enqueues.
`timescale 1ns/1ps
module tb_pipe_traffic_gen;

   localparam int W = 8;
   localparam int C = 16;
   localparam int T = 1023;

   logic          CLK = 1'b0;
   logic          nRST = 1'b0;
   logic          start__ENA = 1'b0;
   logic          start__RDY;
   logic [C-1:0]  start_count = '0;
   logic [W-1:0]  start_base = '0;
   logic          done;
   logic [C-1:0]  errors;
   logic          timed_out;

   PipeIn  #(.width(W)) enq_if ();
   PipeOut #(.width(W)) deq_if ();

   pipe_traffic_gen #(.width(W), .cntw(C), .timeout(T)) dut (
      .CLK         (CLK),
      .nRST        (nRST),
      .start__ENA  (start__ENA),
      .start__RDY  (start__RDY),
      .start_count (start_count),
      .start_base  (start_base),
      .enq         (enq_if),
      .deq         (deq_if),
      .done        (done),
      .errors      (errors),
      .timed_out   (timed_out)
   );

   always #5 CLK = ~CLK;

   // Single-entry pipe model
   logic         full;
   logic [W-1:0] pdata;
   int           enq_n;
   int           corrupt_at = -1;
   logic         blocked = 1'b0;

   assign enq_if.enq__RDY   = !full && !blocked;
   assign deq_if.deq__RDY   = full;
   assign deq_if.first__RDY = full;
   assign deq_if.first      = pdata;

   always @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         full  <= 1'b0;
         pdata <= '0;
      end else if (enq_if.enq__ENA && enq_if.enq__RDY) begin
         full  <= 1'b1;
         pdata <= enq_if.enq_v ^ ((enq_n == corrupt_at) ? 8'h01 : 8'h00);
         enq_n <= enq_n + 1;
      end else if (deq_if.deq__ENA) begin
         full <= 1'b0;
      end
   end

   int total = 0;
   int bad = 0;

   logic [W-1:0] enq_vals[$];
   int           enq_cyc[$];
   int           deq_cyc[$];
   int           done_cyc;
   int           ena_seen;
   logic         rdy_at_done;

   task automatic do_start(input logic [C-1:0] cnt, input logic [W-1:0] b);
      @(negedge CLK);
      start_count = cnt;
      start_base  = b;
      start__ENA  = 1'b1;
      @(posedge CLK);
      #1 start__ENA = 1'b0;
   endtask

   // Records traffic from cycle 1 after start until done or the budget runs out.
   task automatic run_capture(input int budget);
      enq_vals.delete(); enq_cyc.delete(); deq_cyc.delete();
      done_cyc = -1; ena_seen = 0; rdy_at_done = 1'b0;
      for (int c = 1; c <= budget; c++) begin
         @(negedge CLK);
         if (enq_if.enq__ENA || deq_if.deq__ENA) ena_seen++;
         if (enq_if.enq__ENA && enq_if.enq__RDY) begin
            enq_vals.push_back(enq_if.enq_v);
            enq_cyc.push_back(c);
         end
         if (deq_if.deq__ENA) deq_cyc.push_back(c);
         if (done) begin
            done_cyc    = c;
            rdy_at_done = start__RDY;
            break;
         end
      end
   endtask

   task automatic test_reset();
      #1;
      total++; if (start__RDY !== 1'b1) begin bad++; $display("FAIL rst_start_rdy got=%b exp=1", start__RDY); end
      total++; if (enq_if.enq__ENA !== 1'b0) begin bad++; $display("FAIL rst_enq_ena got=%b exp=0", enq_if.enq__ENA); end
      total++; if (deq_if.deq__ENA !== 1'b0) begin bad++; $display("FAIL rst_deq_ena got=%b exp=0", deq_if.deq__ENA); end
      total++; if (enq_if.enq_v !== 8'h00) begin bad++; $display("FAIL rst_enq_v got=%h exp=00", enq_if.enq_v); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", done); end
      total++; if (errors !== 16'd0) begin bad++; $display("FAIL rst_errors got=%0d exp=0", errors); end
      total++; if (timed_out !== 1'b0) begin bad++; $display("FAIL rst_timed_out got=%b exp=0", timed_out); end
      @(negedge CLK); @(negedge CLK);
      nRST = 1'b1;
   endtask

   task automatic test_basic();
      do_start(16'd4, 8'd10);
      run_capture(40);
      total++; if (enq_vals.size() != 4) begin bad++; $display("FAIL basic_enq_count got=%0d exp=4", enq_vals.size()); end
      for (int i = 0; i < 4 && i < enq_vals.size(); i++) begin
         total++; if (enq_vals[i] !== 8'(10 + i)) begin bad++; $display("FAIL basic_enq_v[%0d] got=%0d exp=%0d", i, enq_vals[i], 10 + i); end
         total++; if (enq_cyc[i] != 2*i + 1) begin bad++; $display("FAIL basic_enq_cyc[%0d] got=%0d exp=%0d", i, enq_cyc[i], 2*i + 1); end
      end
      total++; if (deq_cyc.size() != 4 || deq_cyc[deq_cyc.size()-1] != 8) begin bad++; $display("FAIL basic_last_deq got_n=%0d exp cycle 8", deq_cyc.size()); end
      total++; if (done_cyc != 9) begin bad++; $display("FAIL basic_done_cyc got=%0d exp=9", done_cyc); end
      total++; if (rdy_at_done !== 1'b1) begin bad++; $display("FAIL basic_rdy_at_done got=%b exp=1", rdy_at_done); end
      total++; if (errors !== 16'd0) begin bad++; $display("FAIL basic_errors got=%0d exp=0", errors); end
      total++; if (timed_out !== 1'b0) begin bad++; $display("FAIL basic_timed_out got=%b exp=0", timed_out); end
      @(negedge CLK);
      total++; if (done !== 1'b0) begin bad++; $display("FAIL basic_done_pulse got=%b exp=0", done); end
   endtask

   task automatic test_wrap();
      logic [W-1:0] exp_v[3];
      exp_v[0] = 8'hFE; exp_v[1] = 8'hFF; exp_v[2] = 8'h00;
      do_start(16'd3, 8'hFE);
      run_capture(40);
      total++; if (enq_vals.size() != 3) begin bad++; $display("FAIL wrap_enq_count got=%0d exp=3", enq_vals.size()); end
      for (int i = 0; i < 3 && i < enq_vals.size(); i++) begin
         total++; if (enq_vals[i] !== exp_v[i]) begin bad++; $display("FAIL wrap_enq_v[%0d] got=%h exp=%h", i, enq_vals[i], exp_v[i]); end
      end
      total++; if (done_cyc != 7) begin bad++; $display("FAIL wrap_done_cyc got=%0d exp=7", done_cyc); end
      total++; if (errors !== 16'd0) begin bad++; $display("FAIL wrap_errors got=%0d exp=0", errors); end
   endtask

   task automatic test_corrupt();
      corrupt_at = enq_n + 1;
      do_start(16'd5, 8'd20);
      run_capture(40);
      total++; if (deq_cyc.size() != 5 || deq_cyc[deq_cyc.size()-1] != 10) begin bad++; $display("FAIL corrupt_deqs got_n=%0d exp=5 ending cycle 10", deq_cyc.size()); end
      total++; if (done_cyc != 11) begin bad++; $display("FAIL corrupt_done_cyc got=%0d exp=11", done_cyc); end
      total++; if (errors !== 16'd1) begin bad++; $display("FAIL corrupt_errors got=%0d exp=1", errors); end
      @(negedge CLK);
      total++; if (errors !== 16'd1) begin bad++; $display("FAIL corrupt_errors_held got=%0d exp=1", errors); end
      corrupt_at = -1;
   endtask

   task automatic test_timeout();
      blocked = 1'b1;
      do_start(16'd2, 8'd0);
      run_capture(1100);
      total++; if (enq_vals.size() != 0) begin bad++; $display("FAIL to_enq_fires got=%0d exp=0", enq_vals.size()); end
      total++; if (done_cyc != T + 2) begin bad++; $display("FAIL to_done_cyc got=%0d exp=%0d", done_cyc, T + 2); end
      total++; if (timed_out !== 1'b1) begin bad++; $display("FAIL to_timed_out got=%b exp=1", timed_out); end
      total++; if (rdy_at_done !== 1'b1) begin bad++; $display("FAIL to_rdy_at_done got=%b exp=1", rdy_at_done); end
      total++; if (errors !== 16'd0) begin bad++; $display("FAIL to_errors got=%0d exp=0", errors); end
      @(negedge CLK);
      total++; if (timed_out !== 1'b1) begin bad++; $display("FAIL to_sticky got=%b exp=1", timed_out); end
      blocked = 1'b0;
   endtask

   task automatic test_zero();
      do_start(16'd0, 8'd5);
      run_capture(10);
      total++; if (done_cyc != 1) begin bad++; $display("FAIL zero_done_cyc got=%0d exp=1", done_cyc); end
      total++; if (timed_out !== 1'b0) begin bad++; $display("FAIL zero_timed_out_cleared got=%b exp=0", timed_out); end
      for (int c = 0; c < 3; c++) begin
         @(negedge CLK);
         if (enq_if.enq__ENA || deq_if.deq__ENA) ena_seen++;
      end
      total++; if (ena_seen != 0) begin bad++; $display("FAIL zero_ena_seen got=%0d exp=0", ena_seen); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL zero_done_pulse got=%b exp=0", done); end
   endtask

   task automatic test_mid_reset();
      int ndeq;
      bit hit;
      ndeq = 0; hit = 0;
      do_start(16'd6, 8'd50);
      for (int c = 1; c <= 40; c++) begin
         @(negedge CLK);
         if (deq_if.deq__ENA) ndeq++;
         if (ndeq == 2) begin hit = 1; break; end
      end
      total++; if (!hit) begin bad++; $display("FAIL mrst_two_deqs got=%0d exp=2", ndeq); end
      total++; if (enq_if.enq__ENA !== 1'b1) begin bad++; $display("FAIL mrst_running got=%b exp=1", enq_if.enq__ENA); end
      #1 nRST = 1'b0;
      #1;
      total++; if (enq_if.enq__ENA !== 1'b0) begin bad++; $display("FAIL mrst_enq_ena got=%b exp=0", enq_if.enq__ENA); end
      total++; if (deq_if.deq__ENA !== 1'b0) begin bad++; $display("FAIL mrst_deq_ena got=%b exp=0", deq_if.deq__ENA); end
      total++; if (start__RDY !== 1'b1) begin bad++; $display("FAIL mrst_idle got=%b exp=1", start__RDY); end
      total++; if (errors !== 16'd0) begin bad++; $display("FAIL mrst_errors got=%0d exp=0", errors); end
      @(negedge CLK);
      nRST = 1'b1;
      do_start(16'd3, 8'd100);
      run_capture(40);
      total++; if (enq_vals.size() != 3) begin bad++; $display("FAIL mrst_enq_count got=%0d exp=3", enq_vals.size()); end
      for (int i = 0; i < 3 && i < enq_vals.size(); i++) begin
         total++; if (enq_vals[i] !== 8'(100 + i)) begin bad++; $display("FAIL mrst_enq_v[%0d] got=%0d exp=%0d", i, enq_vals[i], 100 + i); end
      end
      total++; if (done_cyc != 7) begin bad++; $display("FAIL mrst_done_cyc got=%0d exp=7", done_cyc); end
      total++; if (errors !== 16'd0) begin bad++; $display("FAIL mrst_errors_after got=%0d exp=0", errors); end
   endtask

   initial begin
      enq_n = 0;
      test_reset();
      test_basic();
      test_wrap();
      test_corrupt();
      test_timeout();
      test_zero();
      test_mid_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pipe_traffic_gen.md
# pipe_traffic_gen

- Drives both client ends of a PipeIn/PipeOut pipe:
  - a source pushes an incrementing sequence into the pipe's enq port;
  - a sink drains the pipe's deq port and checks each value against the expected sequence.
- Used as a self-checking traffic harness around single-entry and deeper pipe buffers, in simulation and on-chip bring-up.
- Reports completion, error count, and a stall timeout.

## Interface

Parameters:
- width, 32, data width of enq$v / first
- cntw, 16, width of transfer count and error counter
- timeout, 1023, consecutive no-progress cycles in RUN before abort

Ports:
- CLK  in  1  clock, all state on posedge
- nRST  in  1  reset, asynchronous, active-low
- start__ENA  in  1  start request; accepted when start__ENA && start__RDY
- start__RDY  out  1  high in IDLE only
- start$count  in  cntw  number of items to send and receive
- start$base  in  width  first sequence value
- enq  PipeIn.client  —  drives enq__ENA, enq$v; samples enq__RDY
- deq  PipeOut.client  —  drives deq__ENA; samples deq__RDY, first, first__RDY
- done  out  1  one-cycle pulse on completion or abort
- errors  out  cntw  mismatches in current/last run, saturating
- timed_out  out  1  last run ended by timeout; sticky until next start

## Operation

- States: IDLE, RUN.
- Registers: count, base, sent, recv, errors, stall, timed_out, done.
- IDLE:
  - start__RDY=1; enq__ENA=0; deq__ENA=0.
  - On start: latch count and base; clear sent, recv, errors, stall and timed_out; go to RUN.
  - If start$count==0: stay IDLE and pulse done next cycle, with no traffic.
- Source (in RUN):
  - enq__ENA = (sent != count).
  - enq$v = base + sent, truncated to width (wraps mod 2^width).
  - The transfer fires only when enq__ENA && enq__RDY; then sent += 1.
- Sink (in RUN):
  - deq__ENA = (recv != count) && deq__RDY && first__RDY.
  - When it fires: compare first to base + recv (mod 2^width); on mismatch, errors += 1, saturating at 2^cntw-1; then recv += 1.
- Enq and deq firing in the same cycle are both counted independently.
- Completion: when the deq that makes recv==count fires, next state is IDLE and done=1 for exactly one cycle.
- Stall:
  - stall resets to 0 in any cycle where enq or deq fires; otherwise it increments.
  - When stall==timeout: go to IDLE, set timed_out=1, pulse done.
- start__ENA while in RUN is ignored.
- Reset values: state IDLE, all counters 0, done 0, errors 0, timed_out 0, start__RDY 1, enq__ENA 0, deq__ENA 0, enq$v = 0.
- Reset asserted mid-run: immediate return to reset values; ENA outputs drop asynchronously with state.

## Timing

- start accepted in cycle 0; RUN begins in cycle 1.
- enq__ENA, deq__ENA and enq$v are combinational from registered state plus sampled RDY. They have no combinational path from start__ENA.
- Against a single-entry pipe (enq__RDY = !full; deq, first ready = full):
  - enq fires in odd cycles, deq in even cycles;
  - the last deq is in cycle 2N;
  - done is high in cycle 2N+1;
  - start__RDY is high again in cycle 2N+1.
- Against a pipe that accepts and delivers every cycle: N items finish with done in cycle N+L+1, where L is the pipe latency.
- errors and timed_out are valid from the done cycle and are held until the next accepted start.

## Structure

- Package pipe_traffic_pkg:
  - state enum {IDLE, RUN};
  - localparam for the saturating counter max;
  - function seq_value(base, idx) for the wrapped addition, shared by source and sink.
- One sub-module: pipe_seq_checker.
  - Contains the sink half: recv counter, compare, saturating errors.
  - Instantiated once.
  - The top keeps the FSM, source and stall timer.

## Test plan

- Single-entry pipe, count=4, base=10 → enq$v sequence 10,11,12,13; done in cycle 9; errors=0; timed_out=0.
- Wrap: width=8, count=3, base=8'hFE → values FE,FF,00; errors=0.
- Corrupting pipe flips bit 0 of the 2nd item, count=5 → errors=1; done after 5th deq.
- Pipe with enq__RDY tied 0, timeout=1023 → no enq fires; done at stall==1023; timed_out=1; start__RDY=1 next cycle.
- count=0 → done pulse in cycle 1; enq__ENA and deq__ENA never asserted.
- nRST pulsed low mid-run after 2 of 6 items → enq__ENA/deq__ENA low immediately, errors=0, state IDLE; a new start with count=3 completes cleanly.
